reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 199 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: in-order allocate/commit, CDB write-back, operand lookup, mispredict flush.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB broadcast to the operand lookup ports.
module reorder_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_is_branch_i,
  output logic        rob_full_o,
  output logic [4:0]  alloc_tag_o,
  input  logic        cdb_valid_i,
  input  logic [4:0]  cdb_tag_i,
  input  logic [31:0] cdb_val_i,
  input  logic        cdb_mispredict_i,
  input  logic [31:0] cdb_pc_i,
  input  logic [4:0]  q1_tag_i,
  input  logic [4:0]  q2_tag_i,
  output logic        q1_ready_o,
  output logic        q2_ready_o,
  output logic [31:0] q1_val_o,
  output logic [31:0] q2_val_o,
  output logic        commit_valid_o,
  output logic [4:0]  commit_rd_o,
  output logic [4:0]  commit_tag_o,
  output logic [31:0] commit_val_o,
  output logic        rollback_o,
  output logic [31:0] rollback_pc_o
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [4:0]       rd;
    logic             is_branch;
    logic             mispredict;
    logic [XLEN-1:0]  val;
    logic [XLEN-1:0]  pc;
  } entry_t;

  entry_t             rob_q [DEPTH];
  entry_t             rob_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               commit_valid_q, commit_valid_d;
  logic [4:0]         commit_rd_q, commit_rd_d;
  logic [TAG_W-1:0]   commit_tag_q, commit_tag_d;
  logic [XLEN-1:0]    commit_val_q, commit_val_d;
  logic               rollback_q, rollback_d;
  logic [XLEN-1:0]    rollback_pc_q, rollback_pc_d;

  entry_t             head_e;
  logic               full;
  logic               do_commit, do_flush, do_alloc;
  logic [PTR_W-1:0]   cdb_idx, q1_idx, q2_idx;
  logic               q1_hit, q2_hit;

  // Tags 1..DEPTH address entries 0..DEPTH-1; tag 0 and out-of-range tags address nothing.
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(DEPTH));
  endfunction

  assign full        = (count_q == CNT_W'(DEPTH));
  assign rob_full_o  = full;
  assign alloc_tag_o = TAG_W'(tail_q) + TAG_W'(1);
  assign head_e      = rob_q[head_q];
  assign cdb_idx     = PTR_W'(cdb_tag_i - TAG_W'(1));
  assign q1_idx      = PTR_W'(q1_tag_i - TAG_W'(1));
  assign q2_idx      = PTR_W'(q2_tag_i - TAG_W'(1));

  assign commit_valid_o = commit_valid_q;
  assign commit_rd_o    = commit_rd_q;
  assign commit_tag_o   = commit_tag_q;
  assign commit_val_o   = commit_val_q;
  assign rollback_o     = rollback_q;
  assign rollback_pc_o  = rollback_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_val_q   <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
    end else begin
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_val_q   <= commit_val_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end

  // Commit decisions use registered ready bits, so a write-back never commits on its own edge.
  always_comb begin
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_val_d   = commit_val_q;
    rollback_d     = rollback_q;
    rollback_pc_d  = rollback_pc_q;
    do_commit      = 1'b0;
    do_flush       = 1'b0;
    do_alloc       = 1'b0;

    if (rdy_i) begin
      commit_valid_d = 1'b0;
      rollback_d     = 1'b0;
      do_commit      = head_e.busy && head_e.ready;
      do_flush       = do_commit && head_e.is_branch && head_e.mispredict;
      do_alloc       = issue_valid_i && !full && !rollback_q && !do_flush;

      if (cdb_valid_i && tag_ok(cdb_tag_i) && rob_q[cdb_idx].busy) begin
        rob_d[cdb_idx].ready      = 1'b1;
        rob_d[cdb_idx].val        = cdb_val_i;
        rob_d[cdb_idx].mispredict = cdb_mispredict_i;
        rob_d[cdb_idx].pc         = cdb_pc_i;
      end

      if (do_commit) begin
        rob_d[head_q].busy  = 1'b0;
        rob_d[head_q].ready = 1'b0;
        commit_valid_d      = 1'b1;
        commit_rd_d         = head_e.is_branch ? 5'd0 : head_e.rd;
        commit_tag_d        = TAG_W'(head_q) + TAG_W'(1);
        commit_val_d        = head_e.val;
        head_d              = head_q + PTR_W'(1);
      end

      if (do_alloc) begin
        rob_d[tail_q].busy       = 1'b1;
        rob_d[tail_q].ready      = 1'b0;
        rob_d[tail_q].rd         = issue_rd_i;
        rob_d[tail_q].is_branch  = issue_is_branch_i;
        rob_d[tail_q].mispredict = 1'b0;
        rob_d[tail_q].val        = '0;
        rob_d[tail_q].pc         = '0;
        tail_d                   = tail_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);

      if (do_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          rob_d[i].busy  = 1'b0;
          rob_d[i].ready = 1'b0;
        end
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
        rollback_d    = 1'b1;
        rollback_pc_d = head_e.pc;
      end
    end
  end

  // Operand lookup from stored entry state, optionally bypassing the live CDB broadcast.
  always_comb begin
    q1_hit     = tag_ok(q1_tag_i) && rob_q[q1_idx].busy && rob_q[q1_idx].ready;
    q2_hit     = tag_ok(q2_tag_i) && rob_q[q2_idx].busy && rob_q[q2_idx].ready;
    q1_ready_o = q1_hit;
    q2_ready_o = q2_hit;
    q1_val_o   = q1_hit ? rob_q[q1_idx].val : '0;
    q2_val_o   = q2_hit ? rob_q[q2_idx].val : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid_i && tag_ok(q1_tag_i) && (cdb_tag_i == q1_tag_i)) begin
      q1_ready_o = 1'b1;
      q1_val_o   = cdb_val_i;
    end
    if (cdb_valid_i && tag_ok(q2_tag_i) && (cdb_tag_i == q2_tag_i)) begin
      q2_ready_o = 1'b1;
      q2_val_o   = cdb_val_i;
    end
`else
    // Without bypass a written-back value becomes visible the cycle after the broadcast.
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized run against a queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_is_branch;
  logic [4:0]  issue_rd;
  logic        rob_full;
  logic [4:0]  alloc_tag;
  logic        cdb_valid, cdb_mispredict;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_val, cdb_pc;
  logic [4:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit_valid;
  logic [4:0]  commit_rd, commit_tag;
  logic [31:0] commit_val;
  logic        rollback;
  logic [31:0] rollback_pc;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy_i(rdy),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_is_branch_i(issue_is_branch),
    .rob_full_o(rob_full), .alloc_tag_o(alloc_tag),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
    .cdb_mispredict_i(cdb_mispredict), .cdb_pc_i(cdb_pc),
    .q1_tag_i(q1_tag), .q2_tag_i(q2_tag),
    .q1_ready_o(q1_ready), .q2_ready_o(q2_ready), .q1_val_o(q1_val), .q2_val_o(q2_val),
    .commit_valid_o(commit_valid), .commit_rd_o(commit_rd), .commit_tag_o(commit_tag),
    .commit_val_o(commit_val), .rollback_o(rollback), .rollback_pc_o(rollback_pc)
  );

  // Reference model: in-flight entries kept oldest-first in a queue.
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          br;
    bit          rdy;
    bit          misp;
    logic [31:0] val;
    logic [31:0] pc;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  bit          e_cv, e_rb;
  logic [4:0]  e_crd, e_ctag;
  logic [31:0] e_cval, e_rbpc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_pc = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic m_reset();
    mq.delete();
    m_tail = 0;
    e_cv = 0; e_rb = 0; e_crd = '0; e_ctag = '0; e_cval = '0; e_rbpc = '0;
  endtask

  function automatic void m_lookup(input logic [4:0] t, output bit r, output logic [31:0] v);
    r = 0; v = '0;
    foreach (mq[k]) if (mq[k].tag == int'(t) && mq[k].rdy) begin r = 1; v = mq[k].val; end
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && t != 0 && t <= 16 && cdb_tag == t) begin r = 1; v = cdb_val; end
`endif
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic m_step();
    bit cm, fl, ok;
    m_ent_t h;
    if (rst) begin m_reset(); return; end
    if (!rdy) return;
    cm = (mq.size() > 0) && mq[0].rdy;
    if (cm) h = mq[0];
    fl = cm && h.br && h.misp;
    ok = issue_valid && (mq.size() < 16) && !e_rb && !fl;
    if (cdb_valid && cdb_tag >= 1 && cdb_tag <= 16)
      foreach (mq[k]) if (mq[k].tag == int'(cdb_tag)) begin
        mq[k].rdy = 1; mq[k].val = cdb_val; mq[k].misp = cdb_mispredict; mq[k].pc = cdb_pc;
      end
    e_cv = 0; e_rb = 0;
    if (cm) begin
      e_cv = 1; e_crd = h.br ? 5'd0 : h.rd; e_ctag = 5'(h.tag); e_cval = h.val;
      void'(mq.pop_front());
      if (fl) begin e_rb = 1; e_rbpc = h.pc; end
    end
    if (ok) begin
      mq.push_back('{tag: m_tail + 1, rd: issue_rd, br: issue_is_branch, rdy: 0, misp: 0, val: '0, pc: '0});
      m_tail = (m_tail + 1) % 16;
    end
    if (fl) begin mq.delete(); m_tail = 0; end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", rob_full); end
    n_cmp++; if (alloc_tag !== 5'd1) begin n_fail++; $display("FAIL reset_alloc_tag: got %0d want 1", alloc_tag); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %b want 0", commit_valid); end
    n_cmp++; if (rollback !== 1'b0) begin n_fail++; $display("FAIL reset_rollback: got %b want 0", rollback); end
    n_cmp++; if ({commit_rd, commit_tag, commit_val, rollback_pc} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got %h/%h/%h/%h want 0", commit_rd, commit_tag, commit_val, rollback_pc); end
  endtask

  task automatic test_in_order();
    logic [4:0]  exp_rd  [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] exp_val [3] = '{32'h11, 32'h22, 32'h33};
    logic [4:0]  cdb_seq [3] = '{5'd2, 5'd1, 5'd3};
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i); #1;
      n_cmp++; if (alloc_tag !== 5'(i)) begin n_fail++; $display("FAIL inorder_alloc_tag: got %0d want %0d", alloc_tag, i); end
      tick();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cdb_valid = 1'b1; cdb_tag = cdb_seq[i]; cdb_val = {28'h0, cdb_seq[i][3:0]} * 32'h11;
      tick();
    end
    cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (commit_valid !== 1'b1 || commit_rd !== exp_rd[i] || commit_tag !== 5'(i + 1) || commit_val !== exp_val[i]) begin
        n_fail++; $display("FAIL inorder_commit%0d: got v=%b rd=%0d tag=%0d val=%h want v=1 rd=%0d tag=%0d val=%h",
                           i, commit_valid, commit_rd, commit_tag, commit_val, exp_rd[i], i + 1, exp_val[i]); end
      tick();
    end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_drain: got %b want 0", commit_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin issue_valid = 1'b1; issue_rd = 5'(i + 1); tick(); end
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", rob_full); end
    n_cmp++; if (alloc_tag !== 5'd1) begin n_fail++; $display("FAIL full_alloc_wrap: got %0d want 1", alloc_tag); end
    issue_rd = 5'd17; tick();
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL full_17th: got %b want 1", rob_full); end
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h5; tick();
    cdb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9; tick();
    issue_valid = 1'b0; #1;
    n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'd1 || commit_rd !== 5'd1 || commit_val !== 32'h5) begin
      n_fail++; $display("FAIL full_commit: got v=%b tag=%0d rd=%0d val=%h want v=1 tag=1 rd=1 val=5",
                         commit_valid, commit_tag, commit_rd, commit_val); end
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL full_after_commit: got %b want 0", rob_full); end
    n_cmp++; if (alloc_tag !== 5'd1) begin n_fail++; $display("FAIL full_no_admit: got %0d want 1", alloc_tag); end
  endtask

  task automatic test_rollback();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_is_branch = 1'b1; tick();
    issue_is_branch = 1'b0;
    for (int i = 2; i <= 4; i++) begin issue_rd = 5'(i); tick(); end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h9; cdb_mispredict = 1'b1; cdb_pc = 32'h1000; tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0; cdb_pc = '0;
    tick();
    q1_tag = 5'd2; #1;
    n_cmp++; if (rollback !== 1'b1 || rollback_pc !== 32'h1000) begin
      n_fail++; $display("FAIL rb_pulse: got rb=%b pc=%h want rb=1 pc=1000", rollback, rollback_pc); end
    n_cmp++; if (commit_valid !== 1'b1 || commit_rd !== 5'd0 || commit_tag !== 5'd1) begin
      n_fail++; $display("FAIL rb_commit: got v=%b rd=%0d tag=%0d want v=1 rd=0 tag=1", commit_valid, commit_rd, commit_tag); end
    n_cmp++; if (alloc_tag !== 5'd1 || rob_full !== 1'b0) begin
      n_fail++; $display("FAIL rb_alloc_tag: got tag=%0d full=%b want tag=1 full=0", alloc_tag, rob_full); end
    n_cmp++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL rb_flushed_entry: got %b want 0", q1_ready); end
    tick();
    n_cmp++; if (rollback !== 1'b0 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL rb_single_cycle: got rb=%b cv=%b want 0 0", rollback, commit_valid); end
  endtask

  task automatic test_query();
    bit          exp_r;
    logic [31:0] exp_v;
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd4; tick(); tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_val = 32'hABCD; q1_tag = 5'd2; #1;
`ifdef ROB_CDB_BYPASS_EN
    exp_r = 1; exp_v = 32'hABCD;
`else
    exp_r = 0; exp_v = 32'h0;
`endif
    n_cmp++; if (q1_ready !== exp_r || q1_val !== exp_v) begin
      n_fail++; $display("FAIL query_cdb_cycle: got r=%b v=%h want r=%b v=%h", q1_ready, q1_val, exp_r, exp_v); end
    tick();
    cdb_valid = 1'b0; q2_tag = 5'd1; #1;
    n_cmp++; if (q1_ready !== 1'b1 || q1_val !== 32'hABCD) begin
      n_fail++; $display("FAIL query_stored: got r=%b v=%h want r=1 v=abcd", q1_ready, q1_val); end
    n_cmp++; if (q2_ready !== 1'b0 || q2_val !== 32'h0) begin
      n_fail++; $display("FAIL query_not_ready: got r=%b v=%h want r=0 v=0", q2_ready, q2_val); end
    q1_tag = 5'd0; #1;
    n_cmp++; if (q1_ready !== 1'b0 || q1_val !== 32'h0) begin
      n_fail++; $display("FAIL query_tag0: got r=%b v=%h want r=0 v=0", q1_ready, q1_val); end
  endtask

  task automatic test_stall();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd6; tick();
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h77; tick();
    cdb_valid = 1'b0; tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (commit_valid !== 1'b1 || commit_rd !== 5'd6 || commit_tag !== 5'd1 || commit_val !== 32'h77) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b rd=%0d tag=%0d val=%h want v=1 rd=6 tag=1 val=77",
                           i, commit_valid, commit_rd, commit_tag, commit_val); end
    end
    rdy = 1'b1; tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", commit_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) begin issue_valid = 1'b1; issue_rd = 5'(i); tick(); end
    issue_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h44; tick();
    cdb_valid = 1'b0; tick();
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_val = 32'h55; tick();
    cdb_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({commit_valid, rollback, commit_rd, commit_tag, commit_val, rollback_pc} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got cv=%b rb=%b rd=%0d tag=%0d val=%h pc=%h want all 0",
                         commit_valid, rollback, commit_rd, commit_tag, commit_val, rollback_pc); end
    n_cmp++; if (alloc_tag !== 5'd1 || rob_full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_alloc: got tag=%0d full=%b want tag=1 full=0", alloc_tag, rob_full); end
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'h33; tick();
    cdb_valid = 1'b0; q1_tag = 5'd3; tick();
    n_cmp++; if (commit_valid !== 1'b0 || q1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late_cdb: got cv=%b qr=%b want 0 0", commit_valid, q1_ready); end
  endtask

  task automatic test_random();
    bit          r;
    logic [31:0] v;
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst             = ($urandom_range(0, 199) == 0);
      rdy             = ($urandom_range(0, 9) != 0);
      issue_valid     = ($urandom_range(0, 9) < 6);
      issue_rd        = 5'($urandom);
      issue_is_branch = ($urandom_range(0, 3) == 0);
      cdb_valid       = ($urandom_range(0, 9) < 7);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) cdb_tag = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else cdb_tag = 5'($urandom_range(0, 19));
      cdb_val         = $urandom;
      cdb_mispredict  = ($urandom_range(0, 7) == 0);
      cdb_pc          = $urandom;
      q1_tag          = 5'($urandom_range(0, 17));
      q2_tag          = (mq.size() > 0) ? 5'(mq[$urandom_range(0, mq.size() - 1)].tag) : 5'($urandom_range(0, 17));
      #1;
      n_cmp++; if (rob_full !== (mq.size() == 16)) begin n_fail++; $display("FAIL rnd_full c%0d: got %b want %b", cyc, rob_full, mq.size() == 16); end
      n_cmp++; if (alloc_tag !== 5'(m_tail + 1)) begin n_fail++; $display("FAIL rnd_alloc_tag c%0d: got %0d want %0d", cyc, alloc_tag, m_tail + 1); end
      m_lookup(q1_tag, r, v);
      n_cmp++; if (q1_ready !== r || q1_val !== v) begin n_fail++; $display("FAIL rnd_q1 c%0d: got r=%b v=%h want r=%b v=%h", cyc, q1_ready, q1_val, r, v); end
      m_lookup(q2_tag, r, v);
      n_cmp++; if (q2_ready !== r || q2_val !== v) begin n_fail++; $display("FAIL rnd_q2 c%0d: got r=%b v=%h want r=%b v=%h", cyc, q2_ready, q2_val, r, v); end
      n_cmp++; if (commit_valid !== e_cv || commit_rd !== e_crd || commit_tag !== e_ctag || commit_val !== e_cval) begin
        n_fail++; $display("FAIL rnd_commit c%0d: got v=%b rd=%0d tag=%0d val=%h want v=%b rd=%0d tag=%0d val=%h",
                           cyc, commit_valid, commit_rd, commit_tag, commit_val, e_cv, e_crd, e_ctag, e_cval); end
      n_cmp++; if (rollback !== e_rb || rollback_pc !== e_rbpc) begin
        n_fail++; $display("FAIL rnd_rollback c%0d: got rb=%b pc=%h want rb=%b pc=%h", cyc, rollback, rollback_pc, e_rb, e_rbpc); end
      m_step();
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_in_order();
    test_full();
    test_rollback();
    test_query();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
